// File: rtl/sync_frame_ctrl.sv
// sync_frame_ctrl
//   Hunts a gated serial bit stream for a 4-bit sync word. It then shifts in a
//   DW-bit payload MSB-first and presents each completed word on a one-deep
//   valid/ready output register. Partial payloads are abandoned after TMO
//   consecutive idle cycles. Words that complete while the output is still
//   occupied are dropped and flagged on a sticky overflow bit.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in         serial data bit
//   in_en      qualifies `in`; a bit is consumed only while in_en=1
//   out_ready  consumer accepts out_data while out_valid=1
//   ovf_clr    synchronous clear of overflow (a same-cycle drop wins)
//   out_data   last completed payload
//   out_valid  out_data holds an unconsumed payload
//   sync_lock  high while collecting payload bits
//   overflow   sticky: a completed payload was dropped
//   frame_cnt  payloads loaded into out_data, wraps modulo 2^CW
//
// State table
//   state   | meaning
//   HUNT    | shifting bits through the sync window, waiting for SYNC
//   PAYLOAD | collecting DW payload bits; idle cycles counted toward timeout

module sync_frame_ctrl #(
  parameter logic [3:0] SYNC = 4'b1001,
  parameter int         DW   = 8,
  parameter int         TMO  = 16,
  parameter int         CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  input  logic          in_en,
  input  logic          out_ready,
  input  logic          ovf_clr,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          sync_lock,
  output logic          overflow,
  output logic [CW-1:0] frame_cnt
);

  localparam int BW = $clog2(DW);
  localparam int IW = $clog2(TMO);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sh_q, sh_d;
  logic [DW-2:0] pay_q, pay_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] word_c;
  logic          done_c;
  logic          load_c;
  logic          drop_c;

  // The completed word includes the bit arriving on the completion cycle,
  // so only DW-1 bits ever need to be held in pay_q.
  assign word_c = {pay_q, in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sh_q    <= '0;
      pay_q   <= '0;
      bit_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      pay_q   <= pay_d;
      bit_q   <= bit_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pay_d   = pay_q;
    bit_d   = bit_q;
    idle_d  = idle_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    load_c  = 1'b0;
    drop_c  = 1'b0;

    case (state_q)
      HUNT: begin
        if (in_en) begin
          // Compare the window including the current bit so overlapping
          // prefixes (e.g. 101001) are still detected.
          if ({sh_q, in} == SYNC) begin
            state_d = PAYLOAD;
            sh_d    = '0;
            bit_d   = '0;
            idle_d  = '0;
          end else begin
            sh_d = {sh_q[1:0], in};
          end
        end
      end
      PAYLOAD: begin
        if (in_en) begin
          pay_d  = word_c[DW-2:0];
          bit_d  = bit_q + BW'(1);
          idle_d = '0;
          if (bit_q == BW'(DW - 1)) begin
            done_c  = 1'b1;
            state_d = HUNT;
            sh_d    = '0;
          end
        end else if (idle_q == IW'(TMO - 1)) begin
          state_d = HUNT;
          sh_d    = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: state_d = HUNT;
    endcase

    // A slot freed by a same-cycle consume can take the new word directly.
    if (done_c) begin
      if (!valid_q || out_ready) load_c = 1'b1;
      else                       drop_c = 1'b1;
    end

    if (load_c) begin
      data_d  = word_c;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (drop_c)       ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sync_lock = (state_q == PAYLOAD);
  assign overflow  = ovf_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sync_frame_ctrl.sv
module tb_sync_frame_ctrl;

  localparam int         DW   = 8;
  localparam int         TMO  = 16;
  localparam int         CW   = 8;
  localparam logic [3:0] SYNC = 4'b1001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_b = 1'b0;
  logic          in_en = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          sync_lock;
  logic          overflow;
  logic [CW-1:0] frame_cnt;

  int tests = 0;
  int fails = 0;
  int lock_cycles = 0;
  int valid_cycles = 0;
  int l0, v0;

  sync_frame_ctrl #(.SYNC(SYNC), .DW(DW), .TMO(TMO), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_b),
    .in_en     (in_en),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sync_lock (sync_lock),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a 4-bit history window while hunting, a bit queue
  // for the payload, and an idle-cycle count; word assembled when the
  // queue reaches DW bits.
  bit            m_locked = 1'b0;
  logic [3:0]    m_hist = '0;
  bit            m_pay[$];
  int            m_idle = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit            v_old, load, drop, done;
  logic [DW-1:0] word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 1'b0; m_hist = '0; m_pay.delete(); m_idle = 0;
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_cnt = '0;
    end else begin
      v_old = m_valid; load = 1'b0; drop = 1'b0; done = 1'b0;
      if (!m_locked) begin
        if (in_en) begin
          m_hist = {m_hist[2:0], in_b};
          if (m_hist == SYNC) begin
            m_locked = 1'b1; m_hist = '0; m_pay.delete(); m_idle = 0;
          end
        end
      end else if (in_en) begin
        m_pay.push_back(in_b);
        m_idle = 0;
        if (m_pay.size() == DW) begin
          word = '0;
          foreach (m_pay[i]) word = {word[DW-2:0], m_pay[i]};
          done = 1'b1; m_locked = 1'b0; m_hist = '0; m_pay.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_locked = 1'b0; m_hist = '0; m_pay.delete();
        end
      end
      if (done) begin
        if (!v_old || out_ready) load = 1'b1;
        else                     drop = 1'b1;
      end
      if (load) begin
        m_data = word; m_valid = 1'b1; m_cnt++;
      end else if (v_old && out_ready) begin
        m_valid = 1'b0;
      end
      if (drop)         m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cycle {lock,valid,ovf,cnt,data}",
          {sync_lock, out_valid, overflow, frame_cnt, out_data},
          {m_locked, m_valid, m_ovf, m_cnt, m_data});
    if (sync_lock === 1'b1) lock_cycles++;
    if (out_valid === 1'b1) valid_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      in_b  = v[i];
      in_en = 1'b1;
      tick();
      in_en = 1'b0;
      repeat (gap) tick();
    end
    in_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    check("reset outputs", {sync_lock, out_valid, overflow, frame_cnt, out_data}, 64'h0);
    check("model reset", {m_locked, m_valid, m_ovf, m_cnt, m_data}, 64'h0);
    tick();
    rst = 1'b0;

    // basic frame
    out_ready = 1'b1;
    l0 = lock_cycles; v0 = valid_cycles;
    send_bits(32'h9, 4, 0);
    send_bits(32'hA5, 8, 0);
    repeat (3) tick();
    check("basic lock cycles", 64'(lock_cycles - l0), 64'd8);
    check("basic valid cycles", 64'(valid_cycles - v0), 64'd1);
    check("basic out_data", 64'(out_data), 64'hA5);
    check("basic frame_cnt", 64'(frame_cnt), 64'd1);
    check("basic overflow", 64'(overflow), 64'd0);
    check("model basic data", 64'(m_data), 64'hA5);

    // overlapping hunt with gated bits
    do_reset();
    out_ready = 1'b1;
    send_bits(32'b10100, 5, 1);
    check("overlap no early lock", 64'(sync_lock), 64'd0);
    send_bits(32'b1, 1, 0);
    check("overlap lock after 6th bit", 64'(sync_lock), 64'd1);
    send_bits(32'h3C, 8, 1);
    repeat (2) tick();
    check("overlap out_data", 64'(out_data), 64'h3C);
    check("overlap frame_cnt", 64'(frame_cnt), 64'd1);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    send_bits(32'h9, 4, 0); send_bits(32'h11, 8, 0);
    send_bits(32'h9, 4, 0); send_bits(32'h22, 8, 0);
    tick();
    check("bp out_data held", 64'(out_data), 64'h11);
    check("bp out_valid", 64'(out_valid), 64'd1);
    check("bp overflow", 64'(overflow), 64'd1);
    check("bp frame_cnt", 64'(frame_cnt), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("bp consumed", 64'(out_valid), 64'd0);
    check("bp overflow sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("bp ovf_clr", 64'(overflow), 64'd0);

    // simultaneous consume and complete
    do_reset();
    out_ready = 1'b0;
    send_bits(32'h9, 4, 0); send_bits(32'h11, 8, 0);
    send_bits(32'h9, 4, 0); send_bits(32'h11, 7, 0);  // top 7 bits of 0x22
    out_ready = 1'b1;
    send_bits(32'h0, 1, 0);                           // last bit of 0x22
    out_ready = 1'b0;
    check("simul out_valid", 64'(out_valid), 64'd1);
    check("simul out_data", 64'(out_data), 64'h22);
    check("simul frame_cnt", 64'(frame_cnt), 64'd2);
    check("simul overflow", 64'(overflow), 64'd0);
    tick();
    check("simul held", {out_valid, out_data}, {1'b1, 8'h22});

    // payload timeout
    do_reset();
    out_ready = 1'b1;
    send_bits(32'h9, 4, 0);
    send_bits(32'b101, 3, 0);
    repeat (TMO - 1) tick();
    check("tmo lock before last idle", 64'(sync_lock), 64'd1);
    tick();
    check("tmo lock after last idle", 64'(sync_lock), 64'd0);
    check("tmo no valid", 64'(out_valid), 64'd0);
    check("tmo frame_cnt", 64'(frame_cnt), 64'd0);
    send_bits(32'h9, 4, 0); send_bits(32'hF0, 8, 0);
    tick();
    check("tmo next out_data", 64'(out_data), 64'hF0);
    check("tmo next frame_cnt", 64'(frame_cnt), 64'd1);

    // async reset mid-payload with a word pending
    do_reset();
    out_ready = 1'b0;
    send_bits(32'h9, 4, 0); send_bits(32'h11, 8, 0);
    send_bits(32'h9, 4, 0); send_bits(32'b1010, 4, 0);
    check("mid lock", 64'(sync_lock), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset outputs", {sync_lock, out_valid, overflow, frame_cnt, out_data}, 64'h0);
    check("model async reset", {m_locked, m_valid, m_cnt}, 64'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send_bits(32'h9, 4, 0); send_bits(32'h5A, 8, 0);
    tick();
    check("post-reset out_data", 64'(out_data), 64'h5A);
    check("post-reset frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_frame_ctrl.md
# sync_frame_ctrl

Serial frame controller that sequences the team's 1001 sync-detector function into a complete receive path. It hunts a gated serial bit stream for a 4-bit sync word, then collects a fixed-width payload MSB-first. Each completed payload is presented on a one-deep valid/ready output register. It sits between the serial line sampler and the word-level consumer, with a payload timeout and sticky overflow reporting.

## Interface
- SYNC, 4'b1001, sync word; the bit received first is compared against SYNC[3]
- DW, 8, payload width in bits (2..32)
- TMO, 16, consecutive idle cycles in PAYLOAD before abort (≥2)
- CW, 8, width of frame_cnt
- clk  input  1  single clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- in  input  1  serial data bit
- in_en  input  1  qualifies `in`; a bit is consumed only on cycles where in_en=1
- out_ready  input  1  consumer accepts out_data when out_valid=1
- ovf_clr  input  1  synchronous clear of the overflow flag
- out_data  output  DW  last completed payload
- out_valid  output  1  out_data holds an unconsumed payload
- sync_lock  output  1  1 while in PAYLOAD state
- overflow  output  1  sticky; a completed payload was dropped
- frame_cnt  output  CW  count of payloads loaded into out_data; wraps modulo 2^CW

## Operation
- Reset values: state=HUNT, shift register=0, bit counter=0, idle counter=0, out_data=0, out_valid=0, sync_lock=0, overflow=0, frame_cnt=0.
- Async reset mid-frame discards the partial payload and any pending out_data.
- States:
  - HUNT: on each in_en, sh <= {sh[2:0], in}.
    - Match when {sh[2:0], in} == SYNC on an in_en cycle, giving overlapping detection; 101001 matches at the sixth bit.
    - On match: go to PAYLOAD, clear sh, bit counter and idle counter.
  - PAYLOAD: on each in_en, pay <= {pay[DW-2:0], in}, bit counter++, idle counter cleared.
    - On a cycle without in_en, idle counter++.
- Completion: an in_en with bit counter == DW-1. The FSM returns to HUNT with sh=0, so there is no overlap into the next sync.
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_data <= completed word (including the current bit), out_valid <= 1, frame_cnt++.
  - Otherwise the word is dropped, overflow <= 1, and out_data, out_valid and frame_cnt are unchanged.
- Timeout: a non-in_en cycle in PAYLOAD with idle counter == TMO-1.
  - Return to HUNT, discard the partial payload, clear sh.
  - No flag is raised, and frame_cnt is unchanged.
- Output handshake: out_valid stays 1 until a cycle with out_ready=1.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Consume with no simultaneous completion: out_valid <= 0.
  - out_ready is ignored while out_valid=0.
- overflow: set by a drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- sync_lock is decoded directly from the registered state; there is no combinational path from `in`.

## Timing
- Sync match on an in_en cycle at edge t: sync_lock=1 from t+1. The first payload bit is the next in_en after t.
- With in_en continuously high: sync_lock is high for exactly DW cycles, and out_valid rises one cycle after the last payload bit is sampled.
- Completion and sync_lock deassert on the same edge.
- Timeout: after TMO consecutive idle cycles in PAYLOAD, sync_lock falls on the edge ending the TMO-th idle cycle.
- Completion while out_valid=1 and out_ready=1: out_valid stays 1 with the new data next cycle. This is a zero-bubble throughput of one word per frame.
- frame_cnt updates on the same edge that loads out_data.

## Test plan
- **Basic frame:** rst pulse, then in_en=1 with bits 1,0,0,1 followed by 0xA5 MSB-first, out_ready=1 → sync_lock high 8 cycles, out_valid 1-cycle pulse with out_data=8'hA5, frame_cnt=1, overflow=0.
- **Overlapping hunt and gating:** bits 1,0,1,0,0,1 then 0x3C, with in_en low every other cycle → lock after the sixth bit, out_data=8'h3C, frame_cnt=1.
- **Backpressure:** out_ready=0, frames 0x11 then 0x22 → out_data=8'h11 held, overflow=1, frame_cnt=1. Then out_ready=1 for one cycle → out_valid=0. Then ovf_clr=1 → overflow=0.
- **Simultaneous consume and complete:** frame 0x11 pending, out_ready=1 exactly on the last-bit cycle of frame 0x22 → out_valid stays 1, out_data=8'h22, frame_cnt=2, overflow=0.
- **Timeout:** 1001 then 3 payload bits, then in_en=0 for 16 cycles → sync_lock falls at the 16th idle edge, no out_valid, frame_cnt unchanged. A following 1001 plus 0xF0 → out_data=8'hF0.
- **Reset mid-payload:** assert rst asynchronously, between clock edges, after 4 payload bits → all outputs immediately at reset values. A fresh frame 0x5A after release → out_data=8'h5A, frame_cnt=1.
